// File: rtl/ip4_rtl_dtlb_if.sv
// Purpose : request/response, page-walker and invalidate signals of the IP4 data TLB.
// Latency : n/a (wires only).
// Backpressure: rdy gates req_en; wk_req is held until wk_ack.
//
// Ports (slave = TLB side):
//   in : req_en, req_vpn, req_st, req_tid, req_k        translation request
//   out: rdy, rsp_en, rsp_pfn, rsp_c, rsp_exp, rsp_code  response
//   out: wk_req, wk_vpn, wk_tid                          walker request
//   in : wk_ack, wk_ok, wk_pfn, wk_w, wk_u, wk_c         walker reply
//   in : inv_en, inv_all, inv_tid                        invalidate
interface ip4_rtl_dtlb_if #(
    parameter int NUM_THREAD = 4,
    parameter int WID_VPN    = 20,
    parameter int WID_PFN    = 20
);
    localparam int WT = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1;

    logic               req_en;
    logic [WID_VPN-1:0] req_vpn;
    logic               req_st;
    logic [WT-1:0]      req_tid;
    logic               req_k;
    logic               rdy;
    logic               rsp_en;
    logic [WID_PFN-1:0] rsp_pfn;
    logic               rsp_c;
    logic               rsp_exp;
    logic [1:0]         rsp_code;
    logic               wk_req;
    logic [WID_VPN-1:0] wk_vpn;
    logic [WT-1:0]      wk_tid;
    logic               wk_ack;
    logic               wk_ok;
    logic [WID_PFN-1:0] wk_pfn;
    logic               wk_w;
    logic               wk_u;
    logic               wk_c;
    logic               inv_en;
    logic               inv_all;
    logic [WT-1:0]      inv_tid;

    modport slave (
        input  req_en, req_vpn, req_st, req_tid, req_k,
        output rdy, rsp_en, rsp_pfn, rsp_c, rsp_exp, rsp_code,
        output wk_req, wk_vpn, wk_tid,
        input  wk_ack, wk_ok, wk_pfn, wk_w, wk_u, wk_c,
        input  inv_en, inv_all, inv_tid
    );

    modport master (
        output req_en, req_vpn, req_st, req_tid, req_k,
        input  rdy, rsp_en, rsp_pfn, rsp_c, rsp_exp, rsp_code,
        input  wk_req, wk_vpn, wk_tid,
        output wk_ack, wk_ok, wk_pfn, wk_w, wk_u, wk_c,
        output inv_en, inv_all, inv_tid
    );
endinterface

// File: rtl/ip4_rtl_dtlb.sv
// Purpose : fully associative, thread-tagged data TLB with page-walker refill.
// Latency : hit -> response 1 cycle after accept; miss -> response 1 cycle after wk_ack.
// Backpressure: rdy=0 while a walk is outstanding; one miss in flight at a time.
//
// Ports: clk, rst_n (async active-low); tlb = ip4_rtl_dtlb_if.slave carrying
// the request, response, walker and invalidate groups.
module ip4_rtl_dtlb #(
    parameter int NUM_ENTRY  = 16,
    parameter int NUM_THREAD = 4,
    parameter int WID_VPN    = 20,
    parameter int WID_PFN    = 20
) (
    input  logic clk,
    input  logic rst_n,
    ip4_rtl_dtlb_if.slave tlb
);
    localparam int WT = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1;
    localparam int WE = $clog2(NUM_ENTRY);

    typedef enum logic {S_IDLE = 1'b0, S_WALK = 1'b1} state_t;

    state_t r_state, w_state_nxt;

    // entry storage
    logic [NUM_ENTRY-1:0] r_vld;
    logic [WT-1:0]        r_tid [NUM_ENTRY];
    logic [WID_VPN-1:0]   r_vpn [NUM_ENTRY];
    logic [WID_PFN-1:0]   r_pfn [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] r_w, r_u, r_c;
    logic [WE-1:0]        r_rr_ptr;

    // outstanding miss context
    logic [WID_VPN-1:0]   r_wk_vpn;
    logic [WT-1:0]        r_wk_tid;
    logic                 r_wk_st, r_wk_k, r_wk_drop;

    // registered response
    logic                 r_rsp_en, r_rsp_c, r_rsp_exp;
    logic [WID_PFN-1:0]   r_rsp_pfn;
    logic [1:0]           r_rsp_code;

    logic [NUM_ENTRY-1:0] w_vld_live, w_hit_vec;
    logic                 w_hit, w_hit_w, w_hit_u, w_hit_c;
    logic [WID_PFN-1:0]   w_hit_pfn;
    logic                 w_free_found;
    logic [WE-1:0]        w_free_idx, w_victim;
    logic                 w_inv_walk, w_miss, w_ack, w_fill;
    logic                 w_rsp_en, w_rsp_c;
    logic [WID_PFN-1:0]   w_rsp_pfn;
    logic [1:0]           w_rsp_code;

    // 2 = user touching a supervisor page, 3 = store to read-only page.
    function automatic logic [1:0] f_perm(input logic k, input logic st,
                                          input logic u, input logic w);
        if (!k && !u)     return 2'd2;
        else if (st && !w) return 2'd3;
        else               return 2'd0;
    endfunction

    // Invalidation is folded in before lookup and victim choice, so a
    // same-cycle invalidate wins over a hit on the entry it clears.
    always_comb begin
        w_vld_live = r_vld;
        w_hit_vec  = '0;
        w_hit_pfn  = '0;
        w_hit_w    = 1'b0;
        w_hit_u    = 1'b0;
        w_hit_c    = 1'b0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (tlb.inv_en && (tlb.inv_all || r_tid[i] == tlb.inv_tid))
                w_vld_live[i] = 1'b0;
            w_hit_vec[i] = w_vld_live[i] && (r_tid[i] == tlb.req_tid) &&
                           (r_vpn[i] == tlb.req_vpn);
            // at most one entry hits, so OR-ing the selected fields is a mux
            if (w_hit_vec[i]) begin
                w_hit_pfn = w_hit_pfn | r_pfn[i];
                w_hit_w   = w_hit_w | r_w[i];
                w_hit_u   = w_hit_u | r_u[i];
                w_hit_c   = w_hit_c | r_c[i];
            end
        end
        w_hit = |w_hit_vec;
    end

    // lowest-index free slot, else round-robin pointer
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (!w_vld_live[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = WE'(i);
            end
        end
        w_victim = w_free_found ? w_free_idx : r_rr_ptr;
    end

    assign w_inv_walk = tlb.inv_en && (tlb.inv_all || tlb.inv_tid == r_wk_tid);
    assign w_miss     = (r_state == S_IDLE) && tlb.req_en && !w_hit;
    assign w_ack      = (r_state == S_WALK) && tlb.wk_ack;
    // a covering invalidate during the walk (including on the ack cycle) drops the fill
    assign w_fill     = w_ack && tlb.wk_ok && !r_wk_drop && !w_inv_walk;

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_en    = 1'b0;
        w_rsp_pfn   = '0;
        w_rsp_c     = 1'b0;
        w_rsp_code  = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (tlb.req_en) begin
                    if (w_hit) begin
                        w_rsp_en   = 1'b1;
                        w_rsp_pfn  = w_hit_pfn;
                        w_rsp_c    = w_hit_c;
                        w_rsp_code = f_perm(tlb.req_k, tlb.req_st, w_hit_u, w_hit_w);
                    end else begin
                        w_state_nxt = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (tlb.wk_ack) begin
                    w_state_nxt = S_IDLE;
                    w_rsp_en    = 1'b1;
                    w_rsp_pfn   = tlb.wk_pfn;
                    w_rsp_c     = tlb.wk_c;
                    w_rsp_code  = tlb.wk_ok ? f_perm(r_wk_k, r_wk_st, tlb.wk_u, tlb.wk_w)
                                            : 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // any exception hides the frame and cacheability
        if (w_rsp_code != 2'd0) begin
            w_rsp_pfn = '0;
            w_rsp_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vld      <= '0;
            r_rr_ptr   <= '0;
            r_wk_vpn   <= '0;
            r_wk_tid   <= '0;
            r_wk_st    <= 1'b0;
            r_wk_k     <= 1'b0;
            r_wk_drop  <= 1'b0;
            r_rsp_en   <= 1'b0;
            r_rsp_pfn  <= '0;
            r_rsp_c    <= 1'b0;
            r_rsp_exp  <= 1'b0;
            r_rsp_code <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rsp_en   <= w_rsp_en;
            r_rsp_pfn  <= w_rsp_pfn;
            r_rsp_c    <= w_rsp_c;
            r_rsp_exp  <= (w_rsp_code != 2'd0);
            r_rsp_code <= w_rsp_code;

            if (w_miss) begin
                r_wk_vpn  <= tlb.req_vpn;
                r_wk_tid  <= tlb.req_tid;
                r_wk_st   <= tlb.req_st;
                r_wk_k    <= tlb.req_k;
                r_wk_drop <= 1'b0;
            end else if (r_state == S_WALK && w_inv_walk) begin
                r_wk_drop <= 1'b1;
            end

            r_vld <= w_vld_live;
            if (w_fill) begin
                r_vld[w_victim] <= 1'b1;
                if (!w_free_found)
                    r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end
    end

    // entry payload needs no reset: it is qualified by r_vld
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tid[w_victim] <= r_wk_tid;
            r_vpn[w_victim] <= r_wk_vpn;
            r_pfn[w_victim] <= tlb.wk_pfn;
            r_w[w_victim]   <= tlb.wk_w;
            r_u[w_victim]   <= tlb.wk_u;
            r_c[w_victim]   <= tlb.wk_c;
        end
    end

    assign tlb.rdy      = (r_state == S_IDLE);
    assign tlb.wk_req   = (r_state == S_WALK);
    assign tlb.wk_vpn   = r_wk_vpn;
    assign tlb.wk_tid   = r_wk_tid;
    assign tlb.rsp_en   = r_rsp_en;
    assign tlb.rsp_pfn  = r_rsp_pfn;
    assign tlb.rsp_c    = r_rsp_c;
    assign tlb.rsp_exp  = r_rsp_exp;
    assign tlb.rsp_code = r_rsp_code;
endmodule

// File: tb/tb_ip4_rtl_dtlb.sv
// Purpose : directed bench for ip4_rtl_dtlb with a behavioural TLB model and per-cycle compare.
// Latency : n/a.
// Backpressure: walker acks are driven at fixed delays; no open-ended waits.
module tb_ip4_rtl_dtlb;
    localparam int NE  = 16;
    localparam int BIG = 32'h7fffffff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ip4_rtl_dtlb_if #(.NUM_THREAD(4), .WID_VPN(20), .WID_PFN(20)) ifc ();

    ip4_rtl_dtlb #(.NUM_ENTRY(NE), .NUM_THREAD(4), .WID_VPN(20), .WID_PFN(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tlb   (ifc)
    );

    typedef struct {
        int          cyc;
        logic [19:0] pfn;
        logic        c;
        logic        exp;
        logic [1:0]  code;
    } rsp_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   ws    = 1;
    int   we    = 0;
    int   walk_cnt = 0;
    rsp_t q[$];
    rsp_t m_last;
    logic m_last_hit;

    // behavioural model of the translation table
    logic        m_vld [NE];
    logic [1:0]  m_tid [NE];
    logic [19:0] m_vpn [NE];
    logic [19:0] m_pfn [NE];
    logic        m_w [NE], m_u [NE], m_c [NE];
    int          m_rr;
    logic [19:0] m_wk_vpn;
    logic [1:0]  m_wk_tid;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] perm(input logic k, input logic st, input logic u, input logic w);
        if (!k && !u) return 2'd2;
        if (st && !w) return 2'd3;
        return 2'd0;
    endfunction

    function automatic rsp_t mk(input int c_at, input logic [19:0] pfn, input logic c, input logic [1:0] code);
        rsp_t r;
        r.cyc  = c_at;
        r.code = code;
        r.exp  = (code != 2'd0);
        r.pfn  = r.exp ? 20'h0 : pfn;
        r.c    = r.exp ? 1'b0 : c;
        return r;
    endfunction

    function automatic int m_find(input logic [19:0] vpn, input logic [1:0] tid);
        for (int i = 0; i < NE; i++)
            if (m_vld[i] && m_vpn[i] == vpn && m_tid[i] == tid) return i;
        return -1;
    endfunction

    task automatic m_inv(input logic all, input logic [1:0] tid);
        for (int i = 0; i < NE; i++)
            if (all || m_tid[i] == tid) m_vld[i] = 1'b0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NE; i++) begin
            m_vld[i] = 1'b0; m_tid[i] = '0; m_vpn[i] = '0; m_pfn[i] = '0;
            m_w[i] = 1'b0; m_u[i] = 1'b0; m_c[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic m_fill(input logic [19:0] vpn, input logic [1:0] tid, input logic [19:0] pfn,
                          input logic w, input logic u, input logic c);
        int v = -1;
        for (int i = NE - 1; i >= 0; i--) if (!m_vld[i]) v = i;
        if (v < 0) begin
            v    = m_rr;
            m_rr = (m_rr + 1) % NE;
        end
        m_vld[v] = 1'b1; m_tid[v] = tid; m_vpn[v] = vpn; m_pfn[v] = pfn;
        m_w[v] = w; m_u[v] = u; m_c[v] = c;
    endtask

    // per-cycle compare of every DUT output against the model's expectation
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_en, exp_wk;
            exp_en = (q.size() > 0) && (q[0].cyc == cyc);
            exp_wk = (cyc >= ws) && (cyc <= we);
            chk("rsp_en", 32'(ifc.rsp_en), 32'(exp_en));
            if (exp_en) begin
                if (ifc.rsp_en) begin
                    chk("rsp_pfn",  32'(ifc.rsp_pfn),  32'(q[0].pfn));
                    chk("rsp_c",    32'(ifc.rsp_c),    32'(q[0].c));
                    chk("rsp_exp",  32'(ifc.rsp_exp),  32'(q[0].exp));
                    chk("rsp_code", 32'(ifc.rsp_code), 32'(q[0].code));
                end
                void'(q.pop_front());
            end
            chk("wk_req", 32'(ifc.wk_req), 32'(exp_wk));
            chk("rdy",    32'(ifc.rdy),    32'(!exp_wk));
            if (exp_wk) begin
                chk("wk_vpn", 32'(ifc.wk_vpn), 32'(m_wk_vpn));
                chk("wk_tid", 32'(ifc.wk_tid), 32'(m_wk_tid));
            end
            if (ifc.wk_req) walk_cnt++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // inv_mode: 0 none, 1 tid-invalidate with the request, 2 tid-invalidate on first walk cycle
    task automatic access(input logic [19:0] vpn, input logic [1:0] tid, input logic st, input logic k,
                          input int dly, input logic ok, input logic [19:0] pfn,
                          input logic w, input logic u, input logic c, input int inv_mode);
        int   idx;
        logic drop;
        walk_cnt = 0;
        drop = 1'b0;
        ifc.req_en = 1'b1; ifc.req_vpn = vpn; ifc.req_tid = tid; ifc.req_st = st; ifc.req_k = k;
        if (inv_mode == 1) begin
            ifc.inv_en = 1'b1; ifc.inv_all = 1'b0; ifc.inv_tid = tid;
            m_inv(1'b0, tid);
        end
        idx = m_find(vpn, tid);
        m_last_hit = (idx >= 0);
        if (idx >= 0) begin
            m_last = mk(cyc + 1, m_pfn[idx], m_c[idx], perm(k, st, m_u[idx], m_w[idx]));
            q.push_back(m_last);
        end else begin
            ws = cyc + 1; we = BIG; m_wk_vpn = vpn; m_wk_tid = tid;
        end
        @(posedge clk); #1;
        ifc.req_en = 1'b0; ifc.inv_en = 1'b0;
        if (idx < 0) begin
            for (int i = 1; i <= dly; i++) begin
                if (i == 1 && inv_mode == 2) begin
                    ifc.inv_en = 1'b1; ifc.inv_all = 1'b0; ifc.inv_tid = tid;
                    m_inv(1'b0, tid);
                    drop = 1'b1;
                end
                if (i == dly) begin
                    ifc.wk_ack = 1'b1; ifc.wk_ok = ok; ifc.wk_pfn = pfn;
                    ifc.wk_w = w; ifc.wk_u = u; ifc.wk_c = c;
                    we = cyc;
                    m_last = ok ? mk(cyc + 1, pfn, c, perm(k, st, u, w)) : mk(cyc + 1, pfn, c, 2'd1);
                    q.push_back(m_last);
                    if (ok && !drop) m_fill(vpn, tid, pfn, w, u, c);
                end
                @(posedge clk); #1;
                ifc.wk_ack = 1'b0; ifc.inv_en = 1'b0;
            end
        end
    endtask

    task automatic inv(input logic all, input logic [1:0] tid);
        ifc.inv_en = 1'b1; ifc.inv_all = all; ifc.inv_tid = tid;
        m_inv(all, tid);
        @(posedge clk); #1;
        ifc.inv_en = 1'b0; ifc.inv_all = 1'b0;
    endtask

    initial begin
        ifc.req_en = 0; ifc.req_vpn = 0; ifc.req_st = 0; ifc.req_tid = 0; ifc.req_k = 0;
        ifc.wk_ack = 0; ifc.wk_ok = 0; ifc.wk_pfn = 0; ifc.wk_w = 0; ifc.wk_u = 0; ifc.wk_c = 0;
        ifc.inv_en = 0; ifc.inv_all = 0; ifc.inv_tid = 0;
        m_reset();
        #12;
        chk("rst_rdy",    32'(ifc.rdy), 32'd1);
        chk("rst_rsp_en", 32'(ifc.rsp_en), 32'd0);
        chk("rst_pfn",    32'(ifc.rsp_pfn), 32'd0);
        chk("rst_exp",    32'({ifc.rsp_c, ifc.rsp_exp, ifc.rsp_code}), 32'd0);
        chk("rst_wk",     32'({ifc.wk_req, ifc.wk_vpn, ifc.wk_tid}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // cold miss, 3-cycle walk, then hit
        access(20'h12345, 2'd1, 0, 1, 3, 1, 20'hABCDE, 1, 0, 1, 0);
        chk("lit_cold_walk", 32'(walk_cnt), 32'd3);
        chk("lit_cold_pfn",  32'(m_last.pfn), 32'hABCDE);
        chk("lit_cold_code", 32'({m_last.c, m_last.code}), 32'b100);
        access(20'h12345, 2'd1, 0, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_hit", 32'(m_last_hit), 32'd1);
        chk("lit_hit_walk", 32'(walk_cnt), 32'd0);

        // permissions
        access(20'h00100, 2'd0, 0, 0, 1, 1, 20'h11111, 1, 0, 1, 0);
        chk("lit_priv", 32'({m_last.pfn, m_last.code}), 32'd2);
        access(20'h00200, 2'd0, 1, 0, 2, 1, 20'h22222, 0, 1, 1, 0);
        chk("lit_wprot_user", 32'(m_last.code), 32'd3);
        access(20'h00200, 2'd0, 1, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_wprot_kern", 32'({m_last_hit, m_last.code}), 32'b111);
        access(20'h00200, 2'd0, 0, 0, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_load_ok", 32'(m_last.pfn), 32'h22222);

        // page fault, not cached
        access(20'h00300, 2'd0, 0, 1, 2, 0, 20'h33333, 1, 1, 1, 0);
        chk("lit_pf", 32'({m_last.exp, m_last.code}), 32'b101);
        access(20'h00300, 2'd0, 0, 1, 2, 0, 20'h33333, 1, 1, 1, 0);
        chk("lit_pf_remiss", 32'(walk_cnt), 32'd2);

        // thread isolation with back-to-back hits
        access(20'h00400, 2'd0, 0, 1, 1, 1, 20'h40000, 1, 1, 1, 0);
        access(20'h00400, 2'd3, 0, 1, 1, 1, 20'h43333, 1, 1, 0, 0);
        access(20'h00400, 2'd0, 0, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_iso_t0", 32'(m_last.pfn), 32'h40000);
        access(20'h00400, 2'd3, 0, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_iso_t3", 32'({m_last.pfn, m_last.c}), 32'({20'h43333, 1'b0}));

        // per-thread invalidate
        access(20'h00500, 2'd2, 0, 1, 1, 1, 20'h55555, 1, 1, 1, 0);
        inv(1'b0, 2'd1);
        access(20'h00500, 2'd2, 0, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_inv_keep", 32'(m_last_hit), 32'd1);
        access(20'h12345, 2'd1, 0, 1, 1, 1, 20'hABCDE, 1, 0, 1, 0);
        chk("lit_inv_gone", 32'(m_last_hit), 32'd0);

        // global invalidate then replacement
        inv(1'b1, 2'd0);
        for (int i = 0; i < NE; i++)
            access(20'h01000 + 20'(i), 2'd0, 0, 1, 1, 1, 20'h80000 + 20'(i), 1, 1, 1, 0);
        access(20'h02000, 2'd0, 0, 1, 1, 1, 20'h90000, 1, 1, 1, 0);
        access(20'h02001, 2'd0, 0, 1, 2, 1, 20'h90001, 1, 1, 1, 0);
        chk("lit_repl_e0", 32'(m_vpn[0]), 32'h02000);
        chk("lit_repl_rr", 32'(m_rr), 32'd2);
        access(20'h01002, 2'd0, 0, 1, 1, 1, 20'h0, 0, 0, 0, 0);
        chk("lit_repl_keep", 32'(m_last_hit), 32'd1);
        access(20'h01000, 2'd0, 0, 1, 1, 1, 20'h80000, 1, 1, 1, 0);
        chk("lit_repl_v0", 32'(m_last_hit), 32'd0);
        access(20'h01001, 2'd0, 0, 1, 1, 1, 20'h80001, 1, 1, 1, 0);
        chk("lit_repl_v1", 32'(m_last_hit), 32'd0);

        // invalidate during walk, on the ack cycle, and with the lookup
        access(20'h03000, 2'd1, 0, 1, 3, 1, 20'hC3000, 1, 1, 1, 2);
        access(20'h03000, 2'd1, 0, 1, 1, 1, 20'hC3000, 1, 1, 1, 0);
        chk("lit_walkinv_drop", 32'(m_last_hit), 32'd0);
        access(20'h03100, 2'd1, 0, 1, 1, 1, 20'hC3100, 1, 1, 1, 2);
        access(20'h03100, 2'd1, 0, 1, 1, 1, 20'hC3100, 1, 1, 1, 0);
        chk("lit_ackinv_drop", 32'(walk_cnt), 32'd1);
        access(20'h03100, 2'd1, 0, 1, 2, 1, 20'hC3100, 1, 1, 1, 1);
        chk("lit_lookupinv", 32'(m_last_hit), 32'd0);

        // reset in the middle of a walk
        ifc.req_en = 1'b1; ifc.req_vpn = 20'h07777; ifc.req_tid = 2'd2; ifc.req_st = 0; ifc.req_k = 1;
        ws = cyc + 1; we = BIG; m_wk_vpn = 20'h07777; m_wk_tid = 2'd2;
        @(posedge clk); #1;
        ifc.req_en = 1'b0;
        @(posedge clk); #1;
        we = cyc - 1;
        rst_n = 1'b0;
        #1;
        chk("rstwalk_wk_req", 32'(ifc.wk_req), 32'd0);
        chk("rstwalk_rdy",    32'(ifc.rdy), 32'd1);
        chk("rstwalk_rsp_en", 32'(ifc.rsp_en), 32'd0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        access(20'h12345, 2'd1, 0, 1, 1, 1, 20'hABCDE, 1, 0, 1, 0);
        chk("lit_post_rst_miss", 32'(m_last_hit), 32'd0);

        idle(3);
        chk("rsp_queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
